// File: rtl/flag_scoreboard_if.sv
// ----------------------------------------------------------------------------
// flag_scoreboard_if
// Bundles the ID/EX flag-scoreboard signals between the pipeline and the
// scoreboard.
//   master : pipeline side; drives ID/EX request fields, observes status
//   slave  : scoreboard side; owns status_ID, flag_stall, err, stall_cnt
// ----------------------------------------------------------------------------
interface flag_scoreboard_if;
   logic        valid_ID;
   logic [3:0]  cond_ID;
   logic        s_ID;
   logic        freeze;
   logic        flush;
   logic        s_EX;
   logic [3:0]  status_EX;
   logic [3:0]  status_ID;
   logic        flag_stall;
   logic        err;
   logic [15:0] stall_cnt;

   modport master (
      output valid_ID, cond_ID, s_ID, freeze, flush, s_EX, status_EX,
      input  status_ID, flag_stall, err, stall_cnt
   );

   modport slave (
      input  valid_ID, cond_ID, s_ID, freeze, flush, s_EX, status_EX,
      output status_ID, flag_stall, err, stall_cnt
   );
endinterface

// File: rtl/flag_scoreboard.sv
// ----------------------------------------------------------------------------
// flag_scoreboard
// Owns the NZCV status register and holds conditionally executed instructions
// in ID until every in-flight flag writer has written its flags in EX.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   bus.slave  : valid_ID, cond_ID, s_ID, freeze, flush, s_EX, status_EX in;
//                status_ID (registered NZCV), flag_stall (combinational hold
//                for ID), err (sticky protocol error), stall_cnt (saturating
//                count of flag-stall cycles) out
// Parameter LAT : cycles from ID issue of a flag setter to its EX write (>=1).
// ----------------------------------------------------------------------------
module flag_scoreboard #(
   parameter int unsigned LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   flag_scoreboard_if.slave bus
);
   localparam int unsigned CNT_W   = 16;
   localparam logic [3:0]  COND_AL = 4'b1110;
   localparam logic [3:0]  COND_NV = 4'b1111;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [LAT-1:0]   pend;
   logic [LAT-1:0]   pend_next;
   logic [3:0]       status_q;
   logic             err_q;
   logic [CNT_W-1:0] stall_cnt_q;
   logic             needs_flags;
   logic             stall;
   logic             issue;
   logic             write_err;

   // Hazard detection and issue qualification
   always_comb begin
      needs_flags = (bus.cond_ID != COND_AL) && (bus.cond_ID != COND_NV);
      stall       = bus.valid_ID & needs_flags & (|pend);
      issue       = bus.valid_ID & bus.s_ID & ~stall & ~bus.freeze & ~bus.flush;
      // EX must write exactly when the oldest tracked writer arrives there
      write_err   = bus.s_EX ^ pend[LAT-1];
   end

   // Writer tracking shift register: newest writer enters at bit 0
   generate
      if (LAT == 1) begin : g_pend_1
         assign pend_next = issue;
      end else begin : g_pend_n
         assign pend_next = {pend[LAT-2:0], issue};
      end
   endgenerate

   // Status, tracking, error and stall-count state; freeze holds everything
   always_ff @(posedge clk) begin
      if (rst) begin
         pend        <= '0;
         status_q    <= 4'b0000;
         err_q       <= 1'b0;
         stall_cnt_q <= '0;
      end else if (!bus.freeze) begin
         pend <= pend_next;
         if (bus.s_EX) begin
            status_q <= bus.status_EX;
         end
         if (write_err) begin
            err_q <= 1'b1;
         end
         if (stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
      end
   end

   assign bus.status_ID  = status_q;
   assign bus.flag_stall = stall;
   assign bus.err        = err_q;
   assign bus.stall_cnt  = stall_cnt_q;
endmodule

// File: doc/flag_scoreboard.md
# flag_scoreboard

Owns the NZCV status register and stalls conditionally executed instructions in ID until all in-flight flag-setting instructions have written their flags. Sits between ID and EX. `status_ID` feeds the ID-stage condition checker. `flag_stall` joins the hazard stall that freezes PC, IF/ID and bubbles ID/EX. The block also tracks issued flag writers, reports protocol violations, and counts stall cycles.

## Interface
- `LAT`, 1: cycles from ID issue of a flag-setting instruction to its flag write in EX (≥1).
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `valid_ID` in 1: ID holds a valid instruction.
- `cond_ID` in 4: condition field of the ID instruction.
- `s_ID` in 1: ID instruction updates flags (S bit).
- `freeze` in 1: global pipeline freeze (memory wait); all stages hold.
- `flush` in 1: branch taken; the IF/ID instruction is killed this cycle.
- `s_EX` in 1: EX instruction writes flags this cycle.
- `status_EX` in 4: ALU flags {N,Z,C,V}.
- `status_ID` out 4: registered status {N,Z,C,V}.
- `flag_stall` out 1: hold ID; combinational.
- `err` out 1: sticky protocol error.
- `stall_cnt` out 16: saturating count of flag-stall cycles.

## Operation
- `needs_flags` = `cond_ID` ∉ {4'b1110 (AL), 4'b1111 (never)}.
- `pend[LAT-1:0]` is a shift register. Bit k set means a flag writer is k+1 stages past ID. `pend[LAT-1]` is the writer expected in EX.
- `flag_stall` = `valid_ID & needs_flags & |pend`.
- `issue` = `valid_ID & s_ID & ~flag_stall & ~freeze & ~flush`.
- A stalled conditional flag-setter is not issued until the stall clears.
- Every edge when `~freeze`:
  - `pend <= {pend[LAT-2:0], issue}`; for LAT=1, `pend <= issue`.
  - If `s_EX`: `status_ID <= status_EX`.
  - If `s_EX & ~pend[LAT-1]` (unexpected write) or `pend[LAT-1] & ~s_EX` (missing write): `err <= 1`.
  - If `flag_stall` and `stall_cnt != 16'hFFFF`: `stall_cnt <= stall_cnt + 1`.
- When `freeze` is high:
  - `pend`, `status_ID` and `stall_cnt` hold.
  - No error check is made. `flag_stall` still reflects current state.
- `flush`:
  - Only suppresses `issue`.
  - Older `pend` bits belong to instructions past ID and shift normally.
  - `flush` with `freeze`: everything holds and nothing is issued.
- No bypass: a flag write becomes visible on `status_ID` the cycle after EX. `pend` covers that window, so stalled instructions never see stale flags.
- Non-conditional instructions (AL/never) never stall, even with writers pending.
- `err` clears only on `rst`.

## Timing
- Reset (`rst` high at an edge): `status_ID`=4'b0000, `pend`=0, `err`=0, `stall_cnt`=0. `flag_stall`=0 from the following cycle.
- `rst` mid-operation discards all pending writers; no error is raised for them.
- LAT=1 example:
  - Writer issued in cycle t. `pend[0]`=1 in t+1; EX writes at the end of t+1.
  - New flags are on `status_ID` in t+2.
  - A conditional instruction in ID at t+1 stalls exactly 1 cycle and proceeds in t+2.
- General LAT: a conditional instruction directly behind a writer stalls LAT cycles.
- Back-to-back writers (AL, S=1) issue every cycle with no stall; `pend` can hold up to LAT ones.
- `stall_cnt` saturates at 16'hFFFF and never wraps.

## Test plan
- Reset, then `s_EX`=1 with `status_EX`=4'b1010 (no issue) → `err`=1 next cycle, `status_ID`=4'b1010. Then `rst` → all outputs 0.
- LAT=1 writer:
  - Issue ADDS (cond=1110, s_ID=1) at t; drive `s_EX`=1, `status_EX`=4'b0100 at t+1.
  - BEQ (cond=0000) in ID at t+1 → `flag_stall`=1 at t+1 only; `status_ID`=4'b0100 at t+2; `err`=0; `stall_cnt`=1.
- Writer in flight, AL instruction in ID → `flag_stall`=0. Same with cond=1111 → `flag_stall`=0.
- Writer in EX with `freeze`=1 for 3 cycles:
  - `flag_stall` stays 1; `pend` and `status_ID` hold; `stall_cnt` unchanged during freeze.
  - Write lands on the first unfrozen edge.
- `flush` with a valid S instruction in ID → `pend` stays 0. Next cycle `s_EX`=0 → `err`=0. Next conditional in ID → no stall.
- LAT=2, writers issued at t and t+1 with `s_EX` at t+2 and t+3 → conditional at t+2 stalls through t+3, proceeds t+4, `err`=0. Force `stall_cnt` to 16'hFFFE, stall 3 cycles → `stall_cnt`=16'hFFFF.
